// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem write bus of the boot loader.
// The master side feeds bytes and observes imem writes; the slave side is the loader.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 12
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_data;
    logic              imem_wren;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_address, imem_data, imem_wren
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_address, imem_data, imem_wren
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed image over a
// valid/ready byte stream, writes it word by word into imem and holds the
// processor in reset until the whole image has been loaded and verified.
// The word counter is 17 bits wide, so ADDR_W must not exceed 16.
module imem_boot_loader #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 1000
) (
    input  logic                clock,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_reset,
    output logic                done,
    output logic                error
);
    localparam int          TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       n_q, n_d;
    logic [16:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;

    logic              rx_ready_c;
    logic              accept_c;
    logic [15:0]       len_c;

    assign rx_ready_c = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept_c   = bus.rx_valid && rx_ready_c;
    assign len_c      = {len_hi_q, bus.rx_data};

    // Next-state logic: frame parsing, word assembly, checksum and idle timeout.
    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        timer_d    = timer_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            S_LEN_HI: begin
                if (accept_c) begin
                    len_hi_d = bus.rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    n_d        = len_c;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                    if ((len_c == 16'd0) || ({1'b0, len_c} > DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], bus.rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word; it is written on the next cycle.
                        wren_d     = 1'b1;
                        data_d     = {shift_q, bus.rx_data};
                        addr_d     = word_idx_q[ADDR_W-1:0];
                        word_idx_d = word_idx_q + 17'd1;
                        if ((word_idx_q + 17'd1) == {1'b0, n_q}) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    state_d = (bus.rx_data == csum_q) ? S_RUN : S_ERR;
                end
            end
            default: begin
                // RUN and ERR are terminal until reset.
            end
        endcase

        // Idle timer runs only once a frame has started and until its checksum arrives.
        if ((state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_CSUM)) begin
            if (accept_c) begin
                timer_d = '0;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                state_d = S_ERR;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    // State register with synchronous reset; reset also cancels any pending write pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_LEN_HI;
            len_hi_q   <= '0;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            timer_q    <= '0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            timer_q    <= timer_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.rx_ready     = rx_ready_c;
    assign bus.imem_wren    = wren_q;
    assign bus.imem_address = addr_q;
    assign bus.imem_data    = data_q;
    assign cpu_reset        = (state_q != S_RUN);
    assign done             = (state_q == S_RUN);
    assign error            = (state_q == S_ERR);
endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: a byte-position model of the frame
// predicts every output each cycle, plus literal checks on the directed images.
module tb_imem_boot_loader;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 1000;
    localparam int DEPTH   = 1 << ADDR_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cpu_reset, done, error;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Status: 0 = loading, 1 = running, 2 = error.
    int          m_k      = 0;   // bytes of the current frame accepted so far
    int          m_n      = 0;
    int          m_idle   = 0;
    int          m_status = 0;
    logic [7:0]  m_xr     = '0;
    logic [31:0] m_wbuf   = '0;
    logic        m_wren   = 1'b0;
    int          m_addr   = 0;
    logic [31:0] m_data   = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_k = 0; m_n = 0; m_idle = 0; m_status = 0; m_xr = '0;
            m_wren = 1'b0; m_addr = 0; m_data = '0;
        end else begin
            m_wren = 1'b0;
            if (m_status == 0) begin
                if (bus.rx_valid) begin
                    if (m_k == 0) begin
                        m_n = int'(bus.rx_data) * 256;
                    end else if (m_k == 1) begin
                        m_n = m_n + int'(bus.rx_data);
                        if (m_n == 0 || m_n > DEPTH) m_status = 2;
                    end else if (m_k < 4 * m_n + 2) begin
                        m_wbuf = {m_wbuf[23:0], bus.rx_data};
                        m_xr   = m_xr ^ bus.rx_data;
                        if ((m_k - 2) % 4 == 3) begin
                            m_wren = 1'b1;
                            m_addr = (m_k - 2) / 4;
                            m_data = m_wbuf;
                        end
                    end else begin
                        m_status = (bus.rx_data == m_xr) ? 1 : 2;
                    end
                    m_k++;
                    m_idle = 0;
                end else if (m_k > 0) begin
                    m_idle++;
                    if (m_idle == TIMEOUT) m_status = 2;
                end
            end
        end
    end

    // ---------------- per-cycle compare and write capture ----------------
    int          wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clock) begin
        if (check_en) begin
            chk("rx_ready",     64'(bus.rx_ready),     64'(m_status == 0));
            chk("imem_wren",    64'(bus.imem_wren),    64'(m_wren));
            chk("imem_address", 64'(bus.imem_address), 64'(m_addr));
            chk("imem_data",    64'(bus.imem_data),    64'(m_data));
            chk("cpu_reset",    64'(cpu_reset),        64'(m_status != 1));
            chk("done",         64'(done),             64'(m_status == 1));
            chk("error",        64'(error),            64'(m_status == 2));
            if (bus.imem_wren === 1'b1) begin
                wa_q.push_back(int'(bus.imem_address));
                wd_q.push_back(bus.imem_data);
            end
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    logic [31:0] w_arr[$];
    logic [7:0]  fb_q[$];

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic build(input int n);
        logic [7:0] x;
        logic [31:0] w;
        x = '0;
        fb_q.delete();
        fb_q.push_back(8'(n >> 8));
        fb_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = w_arr[i];
            for (int j = 3; j >= 0; j--) begin
                fb_q.push_back(w[8*j +: 8]);
                x = x ^ w[8*j +: 8];
            end
        end
        fb_q.push_back(x);
    endtask

    task automatic play(input int gap_max);
        for (int i = 0; i < fb_q.size(); i++) begin
            send(fb_q[i]);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"},  64'(bus.rx_ready),     64'(1));
        chk({tag, "_wren"},      64'(bus.imem_wren),    64'(0));
        chk({tag, "_addr"},      64'(bus.imem_address), 64'(0));
        chk({tag, "_data"},      64'(bus.imem_data),    64'(0));
        chk({tag, "_cpu_reset"}, 64'(cpu_reset),        64'(1));
        chk({tag, "_done"},      64'(done),             64'(0));
        chk({tag, "_error"},     64'(error),            64'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        bit good;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_en = 1'b1;
        check_reset_values("por");
        reset = 1'b0;

        // Two-word image; XOR of the eight data bytes is 0x3E.
        w_arr = '{32'h20010005, 32'h00221820};
        build(2);
        chk("t1_csum_byte", 64'(fb_q[fb_q.size()-1]), 64'(8'h3E));
        play(0);
        chk("t1_done",      64'(done),      64'(1));
        chk("t1_cpu_reset", 64'(cpu_reset), 64'(0));
        chk("t1_nwrites",   64'(wa_q.size()), 64'(2));
        if (wa_q.size() == 2) begin
            chk("t1_addr0", 64'(wa_q[0]), 64'(0));
            chk("t1_data0", 64'(wd_q[0]), 64'(32'h20010005));
            chk("t1_addr1", 64'(wa_q[1]), 64'(1));
            chk("t1_data1", 64'(wd_q[1]), 64'(32'h00221820));
        end
        idle(3);
        chk("t1_done_held", 64'(done), 64'(1));
        $display("frame good_image n=2 writes=%0d done=%0b error=%0b", wa_q.size(), done, error);

        // Same image, bad checksum byte.
        do_reset();
        fb_q[fb_q.size()-1] = 8'h04;
        play(0);
        chk("t2_error",     64'(error),     64'(1));
        chk("t2_cpu_reset", 64'(cpu_reset), 64'(1));
        chk("t2_rx_ready",  64'(bus.rx_ready), 64'(0));
        chk("t2_nwrites",   64'(wa_q.size()), 64'(2));
        for (int i = 0; i < 5; i++) send(8'($urandom));
        chk("t2_error_sticky", 64'(error), 64'(1));
        chk("t2_nwrites_after", 64'(wa_q.size()), 64'(2));
        $display("frame bad_csum n=2 writes=%0d error=%0b", wa_q.size(), error);

        // Illegal lengths.
        do_reset();
        send(8'h00); send(8'h00);
        chk("t3_len0_error", 64'(error), 64'(1));
        idle(6);
        chk("t3_len0_nwrites", 64'(wa_q.size()), 64'(0));
        $display("frame len=0x0000 error=%0b", error);
        do_reset();
        send(8'h10); send(8'h01);
        chk("t3_len4097_error", 64'(error), 64'(1));
        for (int i = 0; i < 8; i++) send(8'($urandom));
        chk("t3_len4097_nwrites", 64'(wa_q.size()), 64'(0));
        $display("frame len=0x1001 error=%0b", error);

        // Stall of TIMEOUT-1 idle cycles is tolerated.
        do_reset();
        w_arr = '{32'hDEADBEEF};
        build(1);
        for (int i = 0; i < 4; i++) send(fb_q[i]);
        idle(TIMEOUT - 1);
        chk("t4_no_timeout", 64'(error), 64'(0));
        for (int i = 4; i < fb_q.size(); i++) send(fb_q[i]);
        chk("t4_done", 64'(done), 64'(1));
        $display("frame stall=%0d done=%0b error=%0b", TIMEOUT - 1, done, error);

        // Stall of TIMEOUT idle cycles fails the load.
        do_reset();
        for (int i = 0; i < 4; i++) send(fb_q[i]);
        idle(TIMEOUT - 1);
        chk("t4_pre_timeout", 64'(error), 64'(0));
        idle(1);
        chk("t4_timeout_error", 64'(error), 64'(1));
        chk("t4_timeout_nwrites", 64'(wa_q.size()), 64'(0));
        $display("frame stall=%0d error=%0b", TIMEOUT, error);

        // Reset after the first of three words, then a fresh one-word image.
        do_reset();
        w_arr = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        build(3);
        for (int i = 0; i < 8; i++) send(fb_q[i]);
        chk("t5_one_written", 64'(wa_q.size()), 64'(1));
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("t5_rst");
        reset = 1'b0;
        wa_q.delete();
        wd_q.delete();
        w_arr = '{32'hCAFEF00D};
        build(1);
        play(1);
        chk("t5_done", 64'(done), 64'(1));
        chk("t5_nwrites", 64'(wa_q.size()), 64'(1));
        if (wa_q.size() == 1) begin
            chk("t5_addr0", 64'(wa_q[0]), 64'(0));
            chk("t5_data0", 64'(wd_q[0]), 64'(32'hCAFEF00D));
        end
        $display("frame after_midload_reset n=1 writes=%0d done=%0b", wa_q.size(), done);

        // Randomized images with random gaps and occasional corrupted checksums.
        for (int f = 0; f < 10; f++) begin
            do_reset();
            n = $urandom_range(1, 8);
            good = ($urandom_range(0, 3) != 0);
            w_arr.delete();
            for (int i = 0; i < n; i++) w_arr.push_back($urandom);
            build(n);
            if (!good) fb_q[fb_q.size()-1] = fb_q[fb_q.size()-1] ^ 8'($urandom_range(1, 255));
            play(3);
            idle(2);
            chk("rand_done",    64'(done),  64'(good));
            chk("rand_error",   64'(error), 64'(!good));
            chk("rand_nwrites", 64'(wa_q.size()), 64'(n));
            $display("frame random %0d n=%0d csum_ok=%0b writes=%0d done=%0b error=%0b",
                     f, n, good, wa_q.size(), done, error);
        end

        // Full-depth image, bytes back to back.
        do_reset();
        w_arr.delete();
        for (int i = 0; i < DEPTH; i++) w_arr.push_back($urandom);
        build(DEPTH);
        play(0);
        chk("full_done",    64'(done), 64'(1));
        chk("full_nwrites", 64'(wa_q.size()), 64'(DEPTH));
        if (wa_q.size() == DEPTH) begin
            chk("full_last_addr", 64'(wa_q[DEPTH-1]), 64'(DEPTH - 1));
            chk("full_last_data", 64'(wd_q[DEPTH-1]), 64'(w_arr[DEPTH-1]));
        end
        $display("frame full_depth n=%0d writes=%0d done=%0b", DEPTH, wa_q.size(), done);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
